// File: rtl/egress_reader_pkg.sv
// Shared definitions for the egress reader: FSM encoding and default widths.
package egress_reader_pkg;

    localparam int unsigned DATA_W_DEF   = 6;
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned DEST_BIT_DEF = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/rx_rr_arb.sv
// Two-way round-robin grant; last = 1 means D1 was served most recently.
module rx_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/egress_reader.sv
// Drains two destination FIFOs round-robin into one registered output stream,
// counting words per source and flagging words that arrived at the wrong FIFO.
module egress_reader
    import egress_reader_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEST_BIT = DEST_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              D0_empty,
    input  logic              D1_empty,
    input  logic [DATA_W-1:0] data_out0,
    input  logic [DATA_W-1:0] data_out1,
    input  logic              sink_pause,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [DATA_W-1:0] data_rx,
    output logic              valid_rx,
    output logic              src_rx,
    output logic [CNT_W-1:0]  count_D0,
    output logic [CNT_W-1:0]  count_D1,
    output logic              dest_error,
    output logic              idle_rx
);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              inflight_q, inflight_d;
    logic              inflight_src_q, inflight_src_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic              err_q, err_d;

    logic [1:0]        grant;
    logic              can_pop;
    logic [DATA_W-1:0] word;

    rx_rr_arb u_arb (
        .req   ({!D1_empty, !D0_empty}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        inflight_d     = 1'b0;
        inflight_src_d = inflight_src_q;
        valid_d        = 1'b0;
        data_d         = data_q;
        src_d          = src_q;
        cnt0_d         = cnt0_q;
        cnt1_d         = cnt1_q;
        err_d          = err_q;
        word           = inflight_src_q ? data_out1 : data_out0;

        can_pop = (state_q == ST_ACTIVE) && !sink_pause && !init;
        pop_D0  = can_pop && grant[0];
        pop_D1  = can_pop && grant[1];

        case (state_q)
            ST_IDLE: begin
                if ((!D0_empty || !D1_empty) && !sink_pause && !init) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (D0_empty && D1_empty && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop_D0 || pop_D1) begin
            inflight_d     = 1'b1;
            inflight_src_d = pop_D1;
            last_d         = pop_D1;
        end

        // FIFO read data is valid the cycle after the pop; capture it here so it
        // appears on the outputs two cycles after the pop, whatever the state.
        if (inflight_q) begin
            valid_d = 1'b1;
            data_d  = word;
            src_d   = inflight_src_q;
            if (inflight_src_q) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
            if (word[DEST_BIT] != inflight_src_q) begin
                err_d = 1'b1;
            end
        end

        if (init) begin
            state_d    = ST_IDLE;
            last_d     = 1'b1;
            inflight_d = 1'b0;
            valid_d    = 1'b0;
            cnt0_d     = '0;
            cnt1_d     = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            last_q         <= 1'b1;
            inflight_q     <= 1'b0;
            inflight_src_q <= 1'b0;
            valid_q        <= 1'b0;
            data_q         <= '0;
            src_q          <= 1'b0;
            cnt0_q         <= '0;
            cnt1_q         <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            inflight_q     <= inflight_d;
            inflight_src_q <= inflight_src_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
            src_q          <= src_d;
            cnt0_q         <= cnt0_d;
            cnt1_q         <= cnt1_d;
            err_q          <= err_d;
        end
    end

    assign data_rx    = data_q;
    assign valid_rx   = valid_q;
    assign src_rx     = src_q;
    assign count_D0   = cnt0_q;
    assign count_D1   = cnt1_q;
    assign dest_error = err_q;
    assign idle_rx    = (state_q == ST_IDLE);

endmodule

// File: doc/egress_reader.md
EGRESS_READER -- requirements
Module: egress_reader

Interface
REQ-001 Parameters SHALL be: DATA_W, default 6, word width; CNT_W, default 8, word-counter width; DEST_BIT, default 4, destination bit index in a word.
REQ-002 Ports SHALL be:
  clk  in  1  single clock; all state on rising edge.
  reset  in  1  asynchronous, active-low.
  init  in  1  synchronous soft clear.
  D0_empty  in  1  empty flag of destination FIFO D0.
  D1_empty  in  1  empty flag of destination FIFO D1.
  data_out0  in  DATA_W  D0 read data, valid the cycle after pop_D0.
  data_out1  in  DATA_W  D1 read data, valid the cycle after pop_D1.
  sink_pause  in  1  downstream requests no new reads.
  pop_D0  out  1  read strobe to D0.
  pop_D1  out  1  read strobe to D1.
  data_rx  out  DATA_W  delivered word.
  valid_rx  out  1  data_rx valid this cycle.
  src_rx  out  1  source of data_rx: 0 = D0, 1 = D1.
  count_D0  out  CNT_W  words delivered from D0.
  count_D1  out  CNT_W  words delivered from D1.
  dest_error  out  1  sticky destination-mismatch flag.
  idle_rx  out  1  block is in IDLE.

Function
REQ-003 FSM states SHALL be IDLE and ACTIVE.
REQ-004 IDLE->ACTIVE SHALL occur when (!D0_empty | !D1_empty) & !sink_pause & !init.
REQ-005 ACTIVE->IDLE SHALL occur when both FIFOs are empty and no read is in flight.
REQ-006 pop_D0/pop_D1 SHALL be combinational, asserted only in ACTIVE, never both in one cycle, never to an empty FIFO, and never while sink_pause or init is 1.
REQ-007 Arbitration SHALL be round-robin: if both FIFOs are non-empty, serve the one not served last; if only one is non-empty, serve it.
REQ-008 One pop SHALL be allowed per cycle, giving a sustained rate of 1 word/cycle.
REQ-009 Latency: a pop in cycle N SHALL put the word on data_rx with valid_rx=1 and the matching src_rx in cycle N+2 (registered capture in N+1).
REQ-010 valid_rx SHALL be 0 in every cycle with no delivered word; data_rx SHALL hold its last value.
REQ-011 A read in flight when sink_pause rises SHALL still be delivered; the sink absorbs at most one such word.
REQ-012 count_Dx SHALL increment by 1 per delivered word from Dx and wrap from 2^CNT_W-1 to 0.
REQ-013 dest_error SHALL set when a D0 word has bit DEST_BIT=1 or a D1 word has bit DEST_BIT=0; it stays set until reset or init.
REQ-014 init=1 SHALL force IDLE, clear both counters, clear dest_error and the arbiter pointer, and discard any in-flight word (no valid_rx).
REQ-015 idle_rx SHALL equal 1 exactly when the state is IDLE.

Reset
REQ-016 While reset=0 the block SHALL hold: state IDLE, pops 0, valid_rx 0, data_rx 0, src_rx 0, counters 0, dest_error 0, idle_rx 1, and the arbiter pointer giving D0 first priority.
REQ-017 Reset asserted mid-transfer SHALL discard the in-flight word; no valid_rx pulse follows reset release.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the DATA_W, CNT_W and DEST_BIT defaults.
REQ-019 Round-robin selection SHALL live in one sub-module, rx_rr_arb (inputs: two requests, last-served pointer; output: one-hot grant).

Verification
REQ-020 Reset release with both FIFOs empty -> idle_rx=1, no pops, all outputs at reset values.
REQ-021 D0 holds 0x01, 0x02, 0x03 and D1 is empty -> pop_D0 in three consecutive cycles; data_rx 0x01, 0x02, 0x03 with src_rx=0 from cycle N+2; count_D0=3; dest_error=0.
REQ-022 D0 holds 0x01, 0x02 and D1 holds 0x11, 0x12 -> pop order D0, D1, D0, D1; output order 0x01, 0x11, 0x02, 0x12; count_D0=2, count_D1=2.
REQ-023 sink_pause raised one cycle after a pop_D0 -> exactly one further valid_rx, then no pops until sink_pause falls.
REQ-024 D0 delivers 0x10 (bit4=1) -> dest_error=1 from the delivery cycle; it stays 1 afterwards; one init pulse clears it to 0.
REQ-025 count_D0 preset to 255 by delivering 255 words, then one more D0 word -> count_D0=0; reset asserted mid-stream -> no valid_rx after release.
